// File: rtl/sig_capture_core.sv
// Circular-buffer signal capture engine with pre-trigger window and pattern/edge trigger.
// Optional SIG_CAPTURE_TSTAMP_EN stores a saturating 16-bit timestamp alongside each sample.
module sig_capture_core #(
    parameter int unsigned CH_NUM   = 3,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned PRE_TRIG = 64,
    localparam int unsigned AW      = $clog2(DEPTH),
`ifdef SIG_CAPTURE_TSTAMP_EN
    localparam int unsigned DW      = CH_NUM + 16
`else
    localparam int unsigned DW      = CH_NUM
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CH_NUM-1:0] data_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              trig_mode_i,
    input  logic [CH_NUM-1:0] trig_mask_i,
    input  logic [CH_NUM-1:0] trig_val_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              busy_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_ptr_o
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

    localparam logic [AW-1:0] PRE_W     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] FILL_LAST = AW'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LEN  = AW'(DEPTH - PRE_TRIG - 1);

    state_t            state, next_state;
    logic [AW-1:0]     wr_ptr, fill_cnt, post_cnt, rd_phys;
    logic [CH_NUM-1:0] prev;
    logic [DW-1:0]     wr_data;
    logic              wr_en, arm_go, trig_hit, trig_cond;
    logic              pat_hit, edge_hit;

    logic [DW-1:0] mem [DEPTH];

    assign pat_hit   = ((data_i ^ trig_val_i) & trig_mask_i) == '0;
    assign edge_hit  = |(trig_mask_i & (prev ^ data_i) & ~(data_i ^ trig_val_i));
    assign trig_cond = trig_mode_i ? edge_hit : pat_hit;

    assign busy_o = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
    assign done_o = (state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        arm_go     = 1'b0;
        trig_hit   = 1'b0;
        if (abort_i) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        arm_go     = 1'b1;
                        next_state = (PRE_TRIG == 0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    wr_en = 1'b1;
                    if (fill_cnt == FILL_LAST) next_state = S_WAIT;
                end
                S_WAIT: begin
                    wr_en = 1'b1;
                    if (trig_cond) begin
                        trig_hit   = 1'b1;
                        next_state = (POST_LEN == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_en = 1'b1;
                    // post_cnt counts remaining writes, so the write with 1 left is the last
                    if (post_cnt == AW'(1)) next_state = S_DONE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            prev        <= '0;
            triggered_o <= 1'b0;
            trig_ptr_o  <= '0;
        end else begin
            prev <= data_i;
            if (arm_go) begin
                wr_ptr   <= '0;
                fill_cnt <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state == S_FILL) fill_cnt <= fill_cnt + 1'b1;
            end
            if (trig_hit)                     post_cnt <= POST_LEN;
            else if (wr_en && state == S_POST) post_cnt <= post_cnt - 1'b1;
            if (abort_i || arm_go) begin
                triggered_o <= 1'b0;
            end else if (trig_hit) begin
                triggered_o <= 1'b1;
                trig_ptr_o  <= wr_ptr;
            end
        end
    end

`ifdef SIG_CAPTURE_TSTAMP_EN
    logic [15:0] tstamp;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                         tstamp <= '0;
        else if (arm_go)                      tstamp <= '0;
        else if (busy_o && (tstamp != '1))    tstamp <= tstamp + 1'b1;
    end

    assign wr_data = {tstamp, data_i};
`else
    assign wr_data = data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_phys = trig_ptr_o - PRE_W + rd_addr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) rd_data_o <= '0;
        else          rd_data_o <= mem[rd_phys];
    end

endmodule

// File: tb/tb_sig_capture_core.sv
// Directed self-checking bench for sig_capture_core (CH_NUM=3, DEPTH=16, PRE_TRIG=4).
module tb_sig_capture_core;

    logic       clk;
    logic       rst_n;
    logic [2:0] data;
    logic       arm;
    logic       abort;
    logic       mode;
    logic [2:0] mask;
    logic [2:0] val;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [3:0] trig_ptr;

    int unsigned n_checks;
    int unsigned n_pass;

    sig_capture_core #(
        .CH_NUM   (3),
        .DEPTH    (16),
        .PRE_TRIG (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .data_i      (data),
        .arm_i       (arm),
        .abort_i     (abort),
        .trig_mode_i (mode),
        .trig_mask_i (mask),
        .trig_val_i  (val),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .triggered_o (triggered),
        .done_o      (done),
        .trig_ptr_o  (trig_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic arm_once();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        data     = '0;
        arm      = 1'b0;
        abort    = 1'b0;
        mode     = 1'b0;
        mask     = '0;
        val      = '0;
        rd_addr  = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_trig", triggered, 0);
        check("rst_done", done, 0);
        check("rst_ptr", trig_ptr, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Pattern trigger on data=5 with a counting input
        mode = 1'b0; mask = 3'b111; val = 3'b101;
        data = 3'd0;
        arm_once();
        check("pat_busy_e0", busy, 1);
        for (int unsigned k = 1; k <= 16; k++) begin
            data = 3'(k % 8);
            tick();
            if (k == 4)  check("pat_notrig_fill", triggered, 0);
            if (k == 5)  check("pat_trig", triggered, 1);
            if (k == 15) check("pat_notdone", done, 0);
        end
        check("pat_ptr", trig_ptr, 4);
        check("pat_done", done, 1);
        check("pat_idle_busy", busy, 0);
        for (int unsigned a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            check($sformatf("pat_rd%0d", a), rd_data, (a + 1) % 8);
        end

        // Edge trigger on ch0 rising; the rise during FILL must be ignored
        mode = 1'b1; mask = 3'b001; val = 3'b001;
        data = 3'd0;
        arm_once();
        check("edge_rearm_clr", triggered, 0);
        for (int unsigned k = 1; k <= 20; k++) begin
            data = 3'((k / 3) % 2);
            tick();
            if (k == 8) check("edge_notrig", triggered, 0);
            if (k == 9) check("edge_trig", triggered, 1);
        end
        check("edge_ptr", trig_ptr, 8);
        check("edge_done", done, 1);
        for (int unsigned a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            check($sformatf("edge_rd%0d", a), rd_data, ((5 + a) / 3) % 2);
        end

        // Pattern mode with empty mask fires on the first WAIT cycle
        mode = 1'b0; mask = 3'b000; val = 3'b000;
        arm_once();
        for (int unsigned k = 1; k <= 16; k++) begin
            data = 3'(k);
            tick();
            if (k == 4) check("pz_notrig", triggered, 0);
            if (k == 5) check("pz_trig", triggered, 1);
        end
        check("pz_ptr", trig_ptr, 4);
        check("pz_done", done, 1);

        // Edge mode with empty mask never fires
        mode = 1'b1; mask = 3'b000;
        arm_once();
        for (int unsigned k = 1; k <= 1000; k++) begin
            data = 3'(k);
            tick();
        end
        check("ez_busy", busy, 1);
        check("ez_done", done, 0);
        check("ez_trig", triggered, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ez_abort_busy", busy, 0);

        // Abort during POST
        mode = 1'b0; mask = 3'b000;
        arm_once();
        for (int unsigned k = 1; k <= 6; k++) tick();
        check("ab_pre_trig", triggered, 1);
        check("ab_pre_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_trig", triggered, 0);
        check("ab_done", done, 0);
        check("ab_ptr_hold", trig_ptr, 4);

        // arm and abort together from IDLE: abort wins
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("armab_busy", busy, 0);
        tick();
        check("armab_busy2", busy, 0);

        // arm while busy is ignored
        arm_once();
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        check("rearm_notrig", triggered, 0);
        tick();
        check("rearm_trig", triggered, 1);
        for (int unsigned k = 6; k <= 16; k++) tick();
        check("rearm_done", done, 1);

        // Trigger after 40 WAIT cycles: pointer wraps, readout stays contiguous
        mode = 1'b0; mask = 3'b111; val = 3'b111;
        data = 3'd0;
        arm_once();
        for (int unsigned k = 1; k <= 56; k++) begin
            data = (k == 45) ? 3'd7 : 3'(k % 7);
            tick();
        end
        check("wrap_ptr", trig_ptr, 12);
        check("wrap_done", done, 1);
        for (int unsigned a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            check($sformatf("wrap_rd%0d", a), rd_data, (a == 4) ? 7 : (41 + a) % 7);
        end

        // Reset in POST
        mask = 3'b000;
        arm_once();
        for (int unsigned k = 1; k <= 7; k++) tick();
        check("rp_busy_pre", busy, 1);
        rst_n = 1'b0;
        tick();
        check("rp_busy", busy, 0);
        check("rp_trig", triggered, 0);
        check("rp_done", done, 0);
        check("rp_ptr", trig_ptr, 0);
        check("rp_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("rp_idle_busy", busy, 0);
        check("rp_idle_done", done, 0);
        arm_once();
        check("rp_arm_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sig_capture_core.md
Name: sig_capture_core

Overview:
- Parametrised in-fabric signal capture engine for on-chip debug of camera sync signals (cmos0/cmos1/pixel vsync and similar).
- Samples CH_NUM probe channels every clk_i cycle into a circular buffer. Supports a pre-trigger window, pattern or edge triggering with per-channel mask, and post-trigger fill.
- Sits beside the camera merge logic; a host-side readout block (UART/register bridge) arms it and reads the frozen buffer.

Parameters:
- CH_NUM, 3, number of probe channels (1..32).
- DEPTH, 256, buffer depth in samples; power of two, 8..4096.
- PRE_TRIG, 64, samples retained before the trigger sample; 0 ≤ PRE_TRIG ≤ DEPTH-1.
- AW, log2(DEPTH), buffer address width; derived, not to be overridden.

Ports:
- clk_i  in  1  sample/system clock.
- rst_n_i  in  1  synchronous active-low reset.
- data_i  in  CH_NUM  probe channels, sampled every cycle.
- arm_i  in  1  single-cycle pulse; starts a capture from IDLE or DONE.
- abort_i  in  1  single-cycle pulse; returns to IDLE from any state.
- trig_mode_i  in  1  trigger mode: 0 = pattern, 1 = edge.
- trig_mask_i  in  CH_NUM  1 = channel participates in the trigger.
- trig_val_i  in  CH_NUM  pattern value, or edge polarity (1 = rising, 0 = falling).
- rd_addr_i  in  AW  logical read index; 0 = oldest sample.
- rd_data_o  out  DW  sample at rd_addr_i, one-cycle latency. DW = CH_NUM, or CH_NUM+16 with the optional feature.
- busy_o  out  1  high in FILL/WAIT/POST.
- triggered_o  out  1  high from the trigger cycle until the next arm, abort or reset.
- done_o  out  1  high in DONE.
- trig_ptr_o  out  AW  physical address of the trigger sample.

Behaviour:
- Reset (rst_n_i low at a clk_i edge):
  - State goes to IDLE.
  - Outputs busy_o, triggered_o, done_o, trig_ptr_o and rd_data_o reset to 0.
  - wr_ptr, fill counter, post counter and prev sample register reset to 0.
  - Buffer contents are not cleared.
  - Reset mid-capture discards the capture.
- States:
  - IDLE: arm_i → FILL.
    - On arm: wr_ptr=0, fill count=0, triggered_o cleared.
    - If PRE_TRIG=0, arm goes directly to WAIT.
  - FILL: write data_i at wr_ptr each cycle; wr_ptr++ (wraps mod DEPTH).
    - After PRE_TRIG writes → WAIT.
    - Trigger conditions are ignored in FILL.
  - WAIT: write every cycle; wr_ptr wraps freely.
    - On a trigger condition this cycle: the current sample is the trigger sample.
    - trig_ptr_o ← wr_ptr; triggered_o ← 1.
    - Post count ← DEPTH-PRE_TRIG-1.
    - → POST; if post count = 0, → DONE.
  - POST: write each cycle; decrement post count; at 0 → DONE.
    - The last write lands at trig_ptr+DEPTH-PRE_TRIG-1.
  - DONE: no writes; the buffer is frozen. arm_i re-arms (→ FILL, as from IDLE).
- Trigger condition (combinational on data_i and prev = data_i registered every cycle in all states):
  - Pattern mode: ((data_i ^ trig_val_i) & trig_mask_i) == 0. A mask of all zeros triggers immediately on entering WAIT.
  - Edge mode: any channel i with mask=1 and prev[i] != data_i[i] and data_i[i] == trig_val_i[i]. A mask of all zeros never triggers.
  - trig_* inputs are sampled live; they must be held stable while busy_o.
- arm_i while busy_o is ignored. arm_i and abort_i in the same cycle: abort wins.
- abort_i: → IDLE. busy_o, triggered_o and done_o drop the next cycle; trig_ptr_o holds its value.
- Readout:
  - Physical address = (trig_ptr_o - PRE_TRIG + rd_addr_i) mod DEPTH, AW-bit wrap arithmetic.
  - Logical index PRE_TRIG is the trigger sample.
  - rd_data_o is registered, valid one cycle after rd_addr_i.
  - Readout is defined only when done_o=1; at other times it returns raw memory.
- Buffer: simple dual-port, inferable as block RAM; write and read never target the same address in DONE.

Optional Feature:
- Macro: SIG_CAPTURE_TSTAMP_EN.
- When defined:
  - A 16-bit timestamp counter clears on arm and increments every cycle while busy_o; it saturates at 0xFFFF.
  - Each stored word is {tstamp[15:0], data_i}, so DW = CH_NUM+16.
  - The trigger sample's timestamp equals the cycle count since arm.
- When undefined: no counter, DW = CH_NUM, identical timing.

Test Plan (CH_NUM=3, DEPTH=16, PRE_TRIG=4):
- Pattern trigger:
  - Stimulus: data_i counts 0..7 repeatedly; mask=3'b111, val=3'b101; arm at t0.
  - Response: FILL for 4 cycles, trigger on the first data_i=5 after FILL, POST 11 cycles, then done_o.
  - Readout 0..15 gives 1,2,3,4,5,6,7,0,1,...
- Edge trigger:
  - Stimulus: ch0 toggles every 3 cycles; mode=1, mask=3'b001, val=1.
  - Response: trigger on the first 0→1 of ch0 after FILL; rd_addr=4 reads ch0=1 and rd_addr=3 reads ch0=0.
- Masks of all zeros:
  - Pattern mode triggers on the first WAIT cycle; trig_ptr_o=4.
  - Edge mode stays in WAIT for 1000 cycles with done_o=0 and busy_o=1.
- Abort and re-arm:
  - abort_i during POST → next cycle busy_o=0, triggered_o=0, done_o=0.
  - arm_i+abort_i in the same cycle from IDLE → stays IDLE.
  - arm_i while busy → ignored (no restart).
- Wrap and reset:
  - Trigger after 40 WAIT cycles: trig_ptr_o = (4+40) mod 16 = 12, and logical readout stays contiguous across the wrap.
  - rst_n_i low in POST: all outputs 0 next cycle and state is IDLE.
- TSTAMP_EN build: pattern trigger at cycle 9 after arm → trigger word timestamp=9, oldest word timestamp=5.
